// File: rtl/urna_pkg.sv
// Shared types and constants for the parametrised ballot recorder.
// Tally saturation is selected by URNA_SATURATE_EN (see urna_tally_cnt).
package urna_pkg;

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    REVIEW = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Entry 0 sits in the low 16 bits, so candidate 0 is keyed as 3-4-9-4.
  localparam logic [63:0] CAND_CODES_DEF = {16'h3504, 16'h3472, 16'h3485, 16'h3494};

  localparam logic STATUS_NULO_IDLE   = 1'b1;
  localparam logic STATUS_VALIDO_IDLE = 1'b0;
  localparam logic STATUS_BRANCO_IDLE = 1'b0;

endpackage

// File: rtl/urna_tally_cnt.sv
// Tally counter with synchronous clear and increment enable.
// URNA_SATURATE_EN defined: holds at all-ones; otherwise wraps.
module urna_tally_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
`ifdef URNA_SATURATE_EN
      if (~&cnt_q) cnt_d = cnt_q + 1'b1;
`else
      cnt_d = cnt_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/urna_param.sv
// Ballot recorder: keys a candidate code, holds it for review, commits on Confirm.
// Tally overflow behaviour follows URNA_SATURATE_EN inside urna_tally_cnt.
module urna_param
  import urna_pkg::*;
#(
  parameter int N_CAND   = 4,
  parameter int N_DIGITS = 4,
  parameter int CNT_W    = 8,
  parameter logic [N_CAND*N_DIGITS*4-1:0] CAND_CODES = CAND_CODES_DEF
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic [3:0]                        Digit,
  input  logic                              Valid,
  input  logic                              Confirm,
  input  logic                              Corrige,
  input  logic                              Branco,
  input  logic                              Next,
  input  logic                              Finish,
  output logic [N_CAND*CNT_W-1:0]           Votos,
  output logic [CNT_W-1:0]                  Nulo,
  output logic [CNT_W-1:0]                  Brancos,
  output logic [CNT_W+3:0]                  Total,
  output logic [$clog2(N_DIGITS+1)-1:0]     Pos,
  output logic                              Revisao,
  output logic                              StatusValido,
  output logic                              StatusNulo,
  output logic                              StatusBranco
);

  localparam int CW    = 4 * N_DIGITS;
  localparam int POS_W = $clog2(N_DIGITS + 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_DIGITS - 1);

  state_e           state_q;
  logic [CW-1:0]    code_q;
  logic [POS_W-1:0] pos_q;
  logic             blank_q;
  logic             st_valido_q;
  logic             st_nulo_q;
  logic             st_branco_q;

  logic              commit_go;
  logic              any_hit;
  logic [N_CAND-1:0] cand_hit;
  logic              tally_clr;

  // First matching entry wins so duplicated codes credit the lowest index.
  always_comb begin
    cand_hit = '0;
    any_hit  = 1'b0;
    for (int i = 0; i < N_CAND; i++) begin
      if (!any_hit && (code_q == CAND_CODES[i*CW +: CW])) begin
        cand_hit[i] = 1'b1;
        any_hit     = 1'b1;
      end
    end
  end

  // Next or Finish during COMMIT discards the pending vote.
  assign commit_go = (state_q == COMMIT) && !Finish && !Next;
  assign tally_clr = Finish;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ENTRY;
      code_q      <= '0;
      pos_q       <= '0;
      blank_q     <= 1'b0;
      st_valido_q <= STATUS_VALIDO_IDLE;
      st_nulo_q   <= STATUS_NULO_IDLE;
      st_branco_q <= STATUS_BRANCO_IDLE;
    end else if (Finish || Next) begin
      state_q     <= ENTRY;
      code_q      <= '0;
      pos_q       <= '0;
      blank_q     <= 1'b0;
      st_valido_q <= STATUS_VALIDO_IDLE;
      st_nulo_q   <= STATUS_NULO_IDLE;
      st_branco_q <= STATUS_BRANCO_IDLE;
    end else begin
      case (state_q)
        ENTRY: begin
          if (Corrige) begin
            code_q <= '0;
            pos_q  <= '0;
          end else if (Confirm) begin
            state_q <= ENTRY;
          end else if (Branco) begin
            if (pos_q == '0) begin
              blank_q <= 1'b1;
              state_q <= REVIEW;
            end
          end else if (Valid) begin
            code_q <= (code_q << 4) | CW'(Digit);
            pos_q  <= pos_q + 1'b1;
            if (pos_q == POS_LAST) state_q <= REVIEW;
          end
        end
        REVIEW: begin
          if (Corrige) begin
            code_q  <= '0;
            pos_q   <= '0;
            blank_q <= 1'b0;
            state_q <= ENTRY;
          end else if (Confirm) begin
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          if (blank_q)      st_branco_q <= 1'b1;
          else if (any_hit) st_valido_q <= 1'b1;
          else              st_nulo_q   <= ~STATUS_NULO_IDLE;
          state_q <= DONE;
        end
        default: state_q <= DONE;
      endcase
    end
  end

  for (genvar i = 0; i < N_CAND; i++) begin : g_votos
    urna_tally_cnt #(.W(CNT_W)) u_cnt (
      .clk_i (Clock),
      .rst_i (Reset),
      .clr_i (tally_clr),
      .inc_i (commit_go && !blank_q && cand_hit[i]),
      .cnt_o (Votos[i*CNT_W +: CNT_W])
    );
  end

  urna_tally_cnt #(.W(CNT_W)) u_nulo (
    .clk_i (Clock),
    .rst_i (Reset),
    .clr_i (tally_clr),
    .inc_i (commit_go && !blank_q && !any_hit),
    .cnt_o (Nulo)
  );

  urna_tally_cnt #(.W(CNT_W)) u_branco (
    .clk_i (Clock),
    .rst_i (Reset),
    .clr_i (tally_clr),
    .inc_i (commit_go && blank_q),
    .cnt_o (Brancos)
  );

  urna_tally_cnt #(.W(CNT_W + 4)) u_total (
    .clk_i (Clock),
    .rst_i (Reset),
    .clr_i (tally_clr),
    .inc_i (commit_go),
    .cnt_o (Total)
  );

  assign Pos          = pos_q;
  assign Revisao      = (state_q == REVIEW);
  assign StatusValido = st_valido_q;
  assign StatusNulo   = st_nulo_q;
  assign StatusBranco = st_branco_q;

endmodule

// File: tb/tb_urna_param.sv
// Bench for urna_param: vote-level reference model checked every cycle plus literal checkpoints.
module tb_urna_param;

  localparam int N_CAND   = 4;
  localparam int N_DIGITS = 4;
  localparam int CNT_W    = 8;
  localparam int POS_W    = 3;

  logic                      Clock = 1'b0;
  logic                      Reset = 1'b1;
  logic [3:0]                Digit = '0;
  logic                      Valid = 1'b0;
  logic                      Confirm = 1'b0;
  logic                      Corrige = 1'b0;
  logic                      Branco = 1'b0;
  logic                      Next = 1'b0;
  logic                      Finish = 1'b0;
  logic [N_CAND*CNT_W-1:0]   Votos;
  logic [CNT_W-1:0]          Nulo;
  logic [CNT_W-1:0]          Brancos;
  logic [CNT_W+3:0]          Total;
  logic [POS_W-1:0]          Pos;
  logic                      Revisao;
  logic                      StatusValido;
  logic                      StatusNulo;
  logic                      StatusBranco;

  urna_param #(
    .N_CAND(N_CAND), .N_DIGITS(N_DIGITS), .CNT_W(CNT_W)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Digit(Digit), .Valid(Valid),
    .Confirm(Confirm), .Corrige(Corrige), .Branco(Branco), .Next(Next),
    .Finish(Finish), .Votos(Votos), .Nulo(Nulo), .Brancos(Brancos),
    .Total(Total), .Pos(Pos), .Revisao(Revisao), .StatusValido(StatusValido),
    .StatusNulo(StatusNulo), .StatusBranco(StatusBranco)
  );

  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (vote-level view) ----------------
  int  codes[N_CAND] = '{32'h3494, 32'h3485, 32'h3472, 32'h3504};
  int  m_votes[N_CAND];
  int  m_nulo, m_branco, m_total;
  int  m_keys[$];
  bit  m_blank, m_review, m_pending, m_done;
  bit  m_sv, m_sn, m_sb;
  bit  armed = 0;

  function automatic int bump(input int v, input int w);
    int lim;
    lim = (1 << w);
`ifdef URNA_SATURATE_EN
    return (v == lim - 1) ? v : v + 1;
`else
    return (v + 1) % lim;
`endif
  endfunction

  function automatic int keyed_value();
    int v;
    v = 0;
    foreach (m_keys[k]) v = v * 16 + m_keys[k];
    return v;
  endfunction

  task automatic m_clear_voter();
    m_keys.delete();
    m_blank = 0; m_review = 0; m_pending = 0; m_done = 0;
    m_sv = 0; m_sn = 1; m_sb = 0;
  endtask

  always @(posedge Clock) begin
    if (Reset || Finish) begin
      foreach (m_votes[i]) m_votes[i] = 0;
      m_nulo = 0; m_branco = 0; m_total = 0;
      m_clear_voter();
    end else if (Next) begin
      m_clear_voter();
    end else if (m_pending) begin
      int who;
      who = -1;
      if (!m_blank)
        for (int i = N_CAND - 1; i >= 0; i--)
          if (keyed_value() == codes[i]) who = i;
      if (m_blank) begin m_branco = bump(m_branco, CNT_W); m_sb = 1; end
      else if (who >= 0) begin m_votes[who] = bump(m_votes[who], CNT_W); m_sv = 1; end
      else begin m_nulo = bump(m_nulo, CNT_W); m_sn = 0; end
      m_total = bump(m_total, CNT_W + 4);
      m_pending = 0; m_done = 1;
    end else if (m_done) begin
      // voter finished, waiting for Next
    end else if (m_review) begin
      if (Corrige) begin m_keys.delete(); m_blank = 0; m_review = 0; end
      else if (Confirm) begin m_review = 0; m_pending = 1; end
    end else begin
      if (Corrige) m_keys.delete();
      else if (Confirm) ;
      else if (Branco) begin
        if (m_keys.size() == 0) begin m_blank = 1; m_review = 1; end
      end else if (Valid) begin
        m_keys.push_back(int'(Digit));
        if (m_keys.size() == N_DIGITS) m_review = 1;
      end
    end
    armed = 1;
  end

  always @(negedge Clock) begin
    if (armed) begin
      for (int i = 0; i < N_CAND; i++)
        chk($sformatf("votos%0d", i), Votos[i*CNT_W +: CNT_W], m_votes[i]);
      chk("nulo", Nulo, m_nulo);
      chk("brancos", Brancos, m_branco);
      chk("total", Total, m_total);
      chk("pos", Pos, (m_review || m_pending || m_done) ? (m_blank ? 0 : N_DIGITS) : m_keys.size());
      chk("revisao", Revisao, m_review);
      chk("st_valido", StatusValido, m_sv);
      chk("st_nulo", StatusNulo, m_sn);
      chk("st_branco", StatusBranco, m_sb);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge Clock); #1;
  endtask

  task automatic key(input int d);
    Digit = 4'(d); Valid = 1; cyc(); Valid = 0;
  endtask

  task automatic keys4(input int a, input int b, input int c, input int d);
    key(a); key(b); key(c); key(d);
  endtask

  task automatic confirm();
    Confirm = 1; cyc(); Confirm = 0; cyc();
  endtask

  task automatic nxt();
    Next = 1; cyc(); Next = 0;
  endtask

  function automatic int votos(input int i);
    return int'(Votos[i*CNT_W +: CNT_W]);
  endfunction

  initial begin
    cyc(); cyc();
    chk("rst_total", Total, 0);
    chk("rst_nulo_st", StatusNulo, 1);
    Reset = 0; cyc();

    keys4(3, 4, 9, 4); confirm();
    chk("v0_after_confirm", votos(0), 1);
    chk("sv_after_confirm", StatusValido, 1);
    chk("total_1", Total, 1);
    nxt();
    chk("sv_after_next", StatusValido, 0);
    chk("pos_after_next", Pos, 0);

    keys4(3, 5, 0, 4); confirm(); nxt();
    keys4(3, 4, 7, 2); confirm();
    chk("v3", votos(3), 1);
    chk("v2", votos(2), 1);
    chk("total_3", Total, 3);
    nxt();

    keys4(1, 2, 3, 4); confirm();
    chk("nulo_1", Nulo, 1);
    chk("sn_low", StatusNulo, 0);
    nxt();
    keys4(3, 4, 9, 15); confirm();
    chk("nulo_2", Nulo, 2);
    nxt();

    Branco = 1; cyc(); Branco = 0;
    chk("blank_review", Revisao, 1);
    confirm();
    chk("brancos_1", Brancos, 1);
    chk("sb_high", StatusBranco, 1);
    nxt();
    key(3); key(4);
    Branco = 1; cyc(); Branco = 0;
    chk("branco_pos2_pos", Pos, 2);
    chk("branco_pos2_rev", Revisao, 0);
    nxt();

    keys4(3, 4, 9, 4);
    Corrige = 1; cyc(); Corrige = 0;
    keys4(3, 4, 8, 5); confirm();
    chk("v0_unchanged", votos(0), 1);
    chk("v1", votos(1), 1);
    nxt();
    keys4(3, 4, 9, 4);
    Confirm = 1; Corrige = 1; cyc(); Confirm = 0; Corrige = 0; cyc();
    chk("corr_win_rev", Revisao, 0);
    chk("corr_win_pos", Pos, 0);
    chk("corr_win_total", Total, 7);
    nxt();

    // Next during COMMIT discards the vote
    keys4(3, 4, 9, 4); Confirm = 1; cyc(); Confirm = 0; Next = 1; cyc(); Next = 0; cyc();
    chk("next_in_commit", Total, 7);

    keys4(3, 4, 9, 4);
    Finish = 1; cyc(); Finish = 0;
    chk("fin_total", Total, 0);
    chk("fin_v1", votos(1), 0);
    chk("fin_rev", Revisao, 0);
    chk("fin_pos", Pos, 0);

    for (int n = 0; n < 256; n++) begin
      keys4(3, 4, 9, 4); confirm(); nxt();
    end
`ifdef URNA_SATURATE_EN
    chk("v0_256", votos(0), 255);
`else
    chk("v0_256", votos(0), 0);
`endif
    chk("total_256", Total, 256);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
